// File: rtl/debouncer_pkg.sv
// Shared constants and helpers for the debouncer block.
package debouncer_pkg;

  localparam int unsigned DEFAULT_COUNT       = 10;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  // Counter width able to hold 0..count-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned count);
    int unsigned w;
    w = $clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debouncer_synchronizer.sv
// Plain flop chain bringing an asynchronous level into the clk domain.
module synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw input through the chain; reset flushes every stage to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Synchronises and debounces one bouncy input; emits one-cycle rise/fall strobes.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned COUNT       = DEFAULT_COUNT,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int unsigned    CW      = cnt_width(COUNT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(COUNT - 1);

  logic          w_s;
  logic [CW-1:0] r_cnt;
  logic          r_out;
  logic          r_rise;
  logic          r_fall;

  synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in),
    .q     (w_s)
  );

  // Count consecutive cycles where the synchronised input disagrees with out;
  // any agreeing cycle restarts the count, a full count commits the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (w_s == r_out) begin
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt  <= '0;
      r_out  <= w_s;
      r_rise <= w_s;
      r_fall <= ~w_s;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  assign out  = r_out;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer: default instance plus a COUNT=1 instance.
module tb_debouncer;

  logic clk;
  logic reset;
  logic in_a, out_a, rise_a, fall_a;
  logic in_b, out_b, rise_b, fall_b;

  int total;
  int bad;

  debouncer #(.COUNT(10), .SYNC_STAGES(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .in    (in_a),
    .out   (out_a),
    .rise  (rise_a),
    .fall  (fall_a)
  );

  debouncer #(.COUNT(1), .SYNC_STAGES(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .in    (in_b),
    .out   (out_b),
    .rise  (rise_b),
    .fall  (fall_b)
  );

  always #1 clk = ~clk;

  // One rising edge, then settle at the falling edge where outputs are sampled
  // and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_a  = 1'b0;
    in_b  = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if ({out_a, rise_a, fall_a} !== 3'b000) begin
        bad++;
        $display("FAIL reset_a cyc=%0d got out/rise/fall=%b%b%b exp=000", k, out_a, rise_a, fall_a);
      end
      total++;
      if ({out_b, rise_b, fall_b} !== 3'b000) begin
        bad++;
        $display("FAIL reset_b cyc=%0d got out/rise/fall=%b%b%b exp=000", k, out_b, rise_b, fall_b);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      total++;
      if ({out_a, rise_a, fall_a} !== 3'b000) begin
        bad++;
        $display("FAIL idle_a cyc=%0d got out/rise/fall=%b%b%b exp=000", k, out_a, rise_a, fall_a);
      end
    end
  endtask

  task automatic test_clean_rise();
    logic eo, er;
    in_a = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      eo = (k >= 12);
      er = (k == 12);
      total++;
      if ({out_a, rise_a, fall_a} !== {eo, er, 1'b0}) begin
        bad++;
        $display("FAIL clean_rise edge=%0d got out/rise/fall=%b%b%b exp=%b%b0", k, out_a, rise_a, fall_a, eo, er);
      end
    end
  endtask

  task automatic test_clean_fall();
    logic eo, ef;
    for (int k = 1; k <= 500; k++) begin
      tick();
      total++;
      if ({out_a, rise_a, fall_a} !== 3'b100) begin
        bad++;
        $display("FAIL hold_high cyc=%0d got out/rise/fall=%b%b%b exp=100", k, out_a, rise_a, fall_a);
      end
    end
    in_a = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      eo = (k < 12);
      ef = (k == 12);
      total++;
      if ({out_a, rise_a, fall_a} !== {eo, 1'b0, ef}) begin
        bad++;
        $display("FAIL clean_fall edge=%0d got out/rise/fall=%b%b%b exp=%b0%b", k, out_a, rise_a, fall_a, eo, ef);
      end
    end
  endtask

  task automatic test_bounce();
    logic eo, er;
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 8; k++) begin
        in_a = (k < 5);
        tick();
        total++;
        if ({out_a, rise_a, fall_a} !== 3'b000) begin
          bad++;
          $display("FAIL bounce burst=%0d cyc=%0d got out/rise/fall=%b%b%b exp=000", n, k, out_a, rise_a, fall_a);
        end
      end
    end
    in_a = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      eo = (k >= 12);
      er = (k == 12);
      total++;
      if ({out_a, rise_a, fall_a} !== {eo, er, 1'b0}) begin
        bad++;
        $display("FAIL bounce_settle edge=%0d got out/rise/fall=%b%b%b exp=%b%b0", k, out_a, rise_a, fall_a, eo, er);
      end
    end
    // Return to a settled low level for the next scenario.
    in_a = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    total++;
    if ({out_a, rise_a, fall_a} !== 3'b000) begin
      bad++;
      $display("FAIL bounce_return got out/rise/fall=%b%b%b exp=000", out_a, rise_a, fall_a);
    end
  endtask

  task automatic test_reset_midcount();
    logic eo, er;
    in_a = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if ({out_a, rise_a, fall_a} !== 3'b000) begin
        bad++;
        $display("FAIL midcount_pre cyc=%0d got out/rise/fall=%b%b%b exp=000", k, out_a, rise_a, fall_a);
      end
    end
    reset = 1'b1;
    tick();
    total++;
    if ({out_a, rise_a, fall_a} !== 3'b000) begin
      bad++;
      $display("FAIL midcount_reset got out/rise/fall=%b%b%b exp=000", out_a, rise_a, fall_a);
    end
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      eo = (k >= 12);
      er = (k == 12);
      total++;
      if ({out_a, rise_a, fall_a} !== {eo, er, 1'b0}) begin
        bad++;
        $display("FAIL midcount_post edge=%0d got out/rise/fall=%b%b%b exp=%b%b0", k, out_a, rise_a, fall_a, eo, er);
      end
    end
  endtask

  task automatic test_count1();
    logic eo, er, ef;
    in_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 2) in_b = 1'b0;
      eo = (k == 3) || (k == 4);
      er = (k == 3);
      ef = (k == 5);
      total++;
      if ({out_b, rise_b, fall_b} !== {eo, er, ef}) begin
        bad++;
        $display("FAIL count1_pulse edge=%0d got out/rise/fall=%b%b%b exp=%b%b%b", k, out_b, rise_b, fall_b, eo, er, ef);
      end
    end
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    in_a  = 1'b0;
    in_b  = 1'b0;
    total = 0;
    bad   = 0;
    @(negedge clk);
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_bounce();
    test_reset_midcount();
    test_count1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
